pwm_dac: RTL and testbench

- Output stage directly downstream of the distortion effect.
- Converts the registered WIDTH-bit unsigned sample stream into a single-bit PWM signal that drives the board's RC-filtered audio output.
- Samples its input once per PWM period and double-buffers it, so a period's duty never changes mid-period.
- Emits a period-start strobe that upstream and test logic can use as the effective sample-rate tick.

---
 rtl/pwm_dac.sv | 74 +++++++
 tb/tb_pwm_dac.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_dac.sv
// pwm_dac: converts a WIDTH-bit unsigned sample stream into a registered single-bit PWM with a period-start strobe.
// Define PWM_DAC_CENTER_ALIGNED_EN for a center-aligned 2^(WIDTH+1)-clock period instead of the edge-aligned default.
module pwm_dac #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] IN,
    input  logic             EN,
    output logic             PWM,
    output logic             SYNC
);

`ifdef PWM_DAC_CENTER_ALIGNED_EN
    localparam int CW = WIDTH + 1;
`else
    localparam int CW = WIDTH;
`endif

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;
    logic             sync_q, sync_d;
`ifdef PWM_DAC_CENTER_ALIGNED_EN
    logic [WIDTH-1:0] tri_val_d;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        duty_d = duty_q;
        sync_d = 1'b0;
        pwm_d  = 1'b0;
`ifdef PWM_DAC_CENTER_ALIGNED_EN
        tri_val_d = '0;
`endif
        if (!EN) begin
            cnt_d = '1;
        end else begin
            // The all-ones count is the last cycle of a period (and the parked state), so the next edge starts a new one
            if (cnt_q == '1) begin
                cnt_d  = '0;
                duty_d = IN;
                sync_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
`ifdef PWM_DAC_CENTER_ALIGNED_EN
            // Triangle folds the up-count about the midpoint: lower half counts down, upper half counts up
            tri_val_d = cnt_d[WIDTH] ? cnt_d[WIDTH-1:0] : ~cnt_d[WIDTH-1:0];
            pwm_d     = (tri_val_d < duty_d);
`else
            pwm_d = (cnt_d < duty_d);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '1;
            duty_q <= '0;
            pwm_q  <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
            sync_q <= sync_d;
        end
    end

    assign PWM  = pwm_q;
    assign SYNC = sync_q;

endmodule

// File: tb/tb_pwm_dac.sv
// tb_pwm_dac: randomized and directed checks of the edge-aligned pwm_dac (WIDTH=8) against a period-level reference model.
module tb_pwm_dac;
    localparam int W = 8;
    localparam int P = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         EN = 1'b0;
    logic [W-1:0] IN = '0;
    logic         PWM;
    logic         SYNC;

    int checks = 0;
    int errors = 0;

    // Reference model: position within the current period (-1 when parked) and the duty latched at its start
    int   m_phase = -1;
    int   m_duty  = 0;
    logic m_pwm   = 1'b0;
    logic m_sync  = 1'b0;

    pwm_dac #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .IN   (IN),
        .EN   (EN),
        .PWM  (PWM),
        .SYNC (SYNC)
    );

    always #5 clk = ~clk;

    // Advance one clock, then update the model from the inputs that were present at the edge
    task automatic tick();
        logic         en_s;
        logic         rst_s;
        logic [W-1:0] in_s;
        en_s  = EN;
        rst_s = rst_n;
        in_s  = IN;
        @(posedge clk);
        #1;
        if (!rst_s) begin
            m_phase = -1;
            m_duty  = 0;
            m_pwm   = 1'b0;
            m_sync  = 1'b0;
        end else if (!en_s) begin
            m_phase = -1;
            m_pwm   = 1'b0;
            m_sync  = 1'b0;
        end else begin
            if (m_phase == -1 || m_phase == P - 1) begin
                m_phase = 0;
                m_duty  = int'(in_s);
                m_sync  = 1'b1;
            end else begin
                m_phase = m_phase + 1;
                m_sync  = 1'b0;
            end
            m_pwm = (m_phase < m_duty);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        EN    = 1'b1;
        IN    = 8'd64;
        #2;
        checks++;
        if (PWM !== 1'b0 || SYNC !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial PWM=%b SYNC=%b required 0 0", PWM, SYNC);
        end
        repeat (3) tick();
        checks++;
        if (PWM !== 1'b0 || SYNC !== 1'b0) begin
            errors++;
            $display("FAIL reset_held PWM=%b SYNC=%b required 0 0", PWM, SYNC);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_hold64();
        int hi;
        hi = 0;
        for (int i = 0; i < 3 * P; i++) begin
            tick();
            if (i == 0) begin
                checks++;
                if (SYNC !== 1'b1 || PWM !== 1'b1) begin
                    errors++;
                    $display("FAIL hold64_first SYNC=%b PWM=%b required 1 1", SYNC, PWM);
                end
            end
            checks++;
            if (SYNC !== (i % P == 0)) begin
                errors++;
                $display("FAIL hold64_sync_spacing cyc=%0d SYNC=%b required %b", i, SYNC, (i % P == 0));
            end
            checks++;
            if (PWM !== m_pwm || SYNC !== m_sync) begin
                errors++;
                $display("FAIL hold64_model cyc=%0d PWM=%b SYNC=%b required %b %b", i, PWM, SYNC, m_pwm, m_sync);
            end
            if (SYNC === 1'b1 && i > 0) begin
                checks++;
                if (hi != 64) begin
                    errors++;
                    $display("FAIL hold64_high_count got=%0d required 64", hi);
                end
                hi = 0;
            end
            if (PWM === 1'b1) hi++;
        end
        checks++;
        if (hi != 64) begin
            errors++;
            $display("FAIL hold64_last_high_count got=%0d required 64", hi);
        end
    endtask

    task automatic test_boundaries();
        int hi;
        hi = 0;
        IN = 8'd0;
        for (int i = 0; i < 2 * P; i++) begin
            tick();
            checks++;
            if (PWM !== m_pwm || SYNC !== m_sync) begin
                errors++;
                $display("FAIL duty0_model cyc=%0d PWM=%b SYNC=%b required %b %b", i, PWM, SYNC, m_pwm, m_sync);
            end
            if (PWM === 1'b1) hi++;
        end
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL duty0_high_count got=%0d required 0", hi);
        end
        hi = 0;
        IN = 8'd255;
        for (int i = 0; i < 2 * P; i++) begin
            tick();
            checks++;
            if (PWM !== (i % P != P - 1)) begin
                errors++;
                $display("FAIL duty255_shape cyc=%0d PWM=%b required %b", i, PWM, (i % P != P - 1));
            end
            checks++;
            if (PWM !== m_pwm || SYNC !== m_sync) begin
                errors++;
                $display("FAIL duty255_model cyc=%0d PWM=%b SYNC=%b required %b %b", i, PWM, SYNC, m_pwm, m_sync);
            end
            if (PWM === 1'b1) hi++;
        end
        checks++;
        if (hi != 2 * (P - 1)) begin
            errors++;
            $display("FAIL duty255_high_count got=%0d required %0d", hi, 2 * (P - 1));
        end
    endtask

    task automatic test_midchange();
        int hi0;
        int hi1;
        hi0 = 0;
        hi1 = 0;
        IN  = 8'd100;
        for (int i = 0; i < 2 * P; i++) begin
            tick();
            checks++;
            if (PWM !== m_pwm || SYNC !== m_sync) begin
                errors++;
                $display("FAIL midchange_model cyc=%0d PWM=%b SYNC=%b required %b %b", i, PWM, SYNC, m_pwm, m_sync);
            end
            if (PWM === 1'b1) begin
                if (i < P) hi0++;
                else hi1++;
            end
            if (i == 50) IN = 8'd10;
        end
        checks++;
        if (hi0 != 100) begin
            errors++;
            $display("FAIL midchange_current got=%0d required 100", hi0);
        end
        checks++;
        if (hi1 != 10) begin
            errors++;
            $display("FAIL midchange_next got=%0d required 10", hi1);
        end
    endtask

    task automatic test_en_drop();
        int hi;
        IN = 8'd128;
        for (int i = 0; i <= 30; i++) tick();
        EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (PWM !== 1'b0 || SYNC !== 1'b0) begin
                errors++;
                $display("FAIL en_low cyc=%0d PWM=%b SYNC=%b required 0 0", i, PWM, SYNC);
            end
        end
        EN = 1'b1;
        IN = 8'd128;
        tick();
        checks++;
        if (SYNC !== 1'b1 || PWM !== 1'b1) begin
            errors++;
            $display("FAIL en_restart SYNC=%b PWM=%b required 1 1", SYNC, PWM);
        end
        hi = (PWM === 1'b1) ? 1 : 0;
        for (int i = 1; i < P; i++) begin
            tick();
            checks++;
            if (PWM !== m_pwm || SYNC !== m_sync) begin
                errors++;
                $display("FAIL en_restart_model cyc=%0d PWM=%b SYNC=%b required %b %b", i, PWM, SYNC, m_pwm, m_sync);
            end
            if (PWM === 1'b1) hi++;
        end
        checks++;
        if (hi != 128) begin
            errors++;
            $display("FAIL en_restart_high_count got=%0d required 128", hi);
        end
    endtask

    task automatic test_reset_mid();
        int hi;
        IN = 8'd200;
        for (int i = 0; i <= 20; i++) tick();
        checks++;
        if (PWM !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre PWM=%b required 1", PWM);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (PWM !== 1'b0 || SYNC !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async PWM=%b SYNC=%b required 0 0", PWM, SYNC);
        end
        tick();
        tick();
        rst_n = 1'b1;
        IN    = 8'd77;
        tick();
        checks++;
        if (SYNC !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_first_sync SYNC=%b required 1", SYNC);
        end
        hi = (PWM === 1'b1) ? 1 : 0;
        IN = 8'd3;
        for (int i = 1; i < P; i++) begin
            tick();
            checks++;
            if (PWM !== m_pwm || SYNC !== m_sync) begin
                errors++;
                $display("FAIL reset_mid_model cyc=%0d PWM=%b SYNC=%b required %b %b", i, PWM, SYNC, m_pwm, m_sync);
            end
            if (PWM === 1'b1) hi++;
        end
        checks++;
        if (hi != 77) begin
            errors++;
            $display("FAIL reset_mid_high_count got=%0d required 77", hi);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            IN = W'($urandom);
            EN = ($urandom_range(0, 299) != 0);
            tick();
            checks++;
            if (PWM !== m_pwm || SYNC !== m_sync) begin
                errors++;
                $display("FAIL random_model cyc=%0d PWM=%b SYNC=%b required %b %b", i, PWM, SYNC, m_pwm, m_sync);
            end
        end
        EN = 1'b1;
    endtask

    initial begin
        test_reset();
        test_hold64();
        test_boundaries();
        test_midchange();
        test_en_drop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
